// File: rtl/io_command_responder.sv
`default_nettype none
// io_command_responder - target-side IO command endpoint: local register file, read and event responses.
// Rev 1.0
module io_command_responder #(
    parameter int PORTBYTEWIDTH = 4,
    parameter int REGCOUNT      = 8,
    parameter int REGBITWIDTH   = 16,
    parameter int EVENTWIDTH    = 8
) (
    input  logic                            target_clk,
    input  logic                            async_rst_n,
    input  logic                            clk_en,
    input  logic                            CmdACK,
    output logic                            CmdREQ,
    input  logic [3:0]                      CmdDestReg,
    input  logic [PORTBYTEWIDTH*8-1:0]      CmdData,
    output logic                            RespACK,
    input  logic                            RespREQ,
    output logic                            RespRegFlag,
    output logic [3:0]                      RespDestReg,
    output logic [PORTBYTEWIDTH*8-1:0]      RespData,
    input  logic [EVENTWIDTH-1:0]           EventIn,
    output logic [REGCOUNT*REGBITWIDTH-1:0] RegOut
);
    localparam int DW = PORTBYTEWIDTH * 8;
    localparam int AW = (REGCOUNT > 1) ? $clog2(REGCOUNT) : 1;
    localparam logic [AW-1:0] STATUS_ADDR = AW'(REGCOUNT - 1);

    localparam logic [4:0] OP_WRITE   = 5'h01;
    localparam logic [4:0] OP_READ    = 5'h02;
    localparam logic [4:0] OP_SETBITS = 5'h03;
    localparam logic [4:0] OP_CLRBITS = 5'h04;
    localparam logic [4:0] OP_CLOCK   = 5'h1F;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESP_READ  = 2'd1,
        RESP_EVENT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [EVENTWIDTH-1:0]   pending_q, pending_d;
    logic                    err_q, err_d;
    logic                    fair_q, fair_d;
    logic                    resp_flag_q, resp_flag_d;
    logic [3:0]              resp_dest_q, resp_dest_d;
    logic [DW-1:0]           resp_data_q, resp_data_d;
    logic [REGBITWIDTH-1:0]  regs_q [REGCOUNT];
    logic [REGBITWIDTH-1:0]  regs_d [REGCOUNT];

    logic [4:0]              w_op;
    logic [AW-1:0]           w_addr;
    logic [REGBITWIDTH-1:0]  w_pay;
    logic                    w_is_status;
    logic [REGBITWIDTH-1:0]  w_status;
    logic [REGBITWIDTH-1:0]  w_rd_val;
    logic                    w_evt_prio;
    logic                    w_unused;

    // Low address bits only: addresses beyond the register count alias.
    assign w_op        = CmdData[DW-1 -: 5];
    assign w_addr      = CmdData[DW-8 +: AW];
    assign w_pay       = CmdData[REGBITWIDTH-1:0];
    assign w_is_status = (w_addr == STATUS_ADDR);
    assign w_unused    = ^CmdData;

    always_comb begin
        w_status               = '0;
        w_status[0]            = err_q;
        w_status[EVENTWIDTH:1] = pending_q;
    end

    assign w_rd_val   = w_is_status ? w_status : regs_q[w_addr];
    assign w_evt_prio = (|pending_q) && !fair_q;

    assign CmdREQ      = async_rst_n && clk_en && (state_q == IDLE) && !w_evt_prio;
    assign RespACK     = clk_en && (state_q != IDLE);
    assign RespRegFlag = resp_flag_q;
    assign RespDestReg = resp_dest_q;
    assign RespData    = resp_data_q;

    for (genvar gi = 0; gi < REGCOUNT; gi++) begin : g_regout
        if (gi == REGCOUNT - 1) begin : g_status
            assign RegOut[gi*REGBITWIDTH +: REGBITWIDTH] = w_status;
        end else begin : g_plain
            assign RegOut[gi*REGBITWIDTH +: REGBITWIDTH] = regs_q[gi];
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        err_d       = err_q;
        fair_d      = fair_q;
        resp_flag_d = resp_flag_q;
        resp_dest_d = resp_dest_q;
        resp_data_d = resp_data_q;
        for (int i = 0; i < REGCOUNT; i++) begin
            regs_d[i] = regs_q[i];
        end

        if (clk_en) begin
            pending_d = pending_q | EventIn;
            case (state_q)
                IDLE: begin
                    if (w_evt_prio) begin
                        // Events arriving in the launch cycle seed the next pending vector.
                        resp_flag_d = 1'b0;
                        resp_dest_d = 4'h0;
                        resp_data_d = DW'(pending_q);
                        pending_d   = EventIn;
                        fair_d      = 1'b1;
                        state_d     = RESP_EVENT;
                    end else begin
                        fair_d = 1'b0;
                        if (CmdACK) begin
                            case (w_op)
                                OP_WRITE: begin
                                    if (w_is_status) begin
                                        if (w_pay[0]) err_d = 1'b0;
                                    end else begin
                                        regs_d[w_addr] = w_pay;
                                    end
                                end
                                OP_READ: begin
                                    resp_flag_d = 1'b1;
                                    resp_dest_d = CmdDestReg;
                                    resp_data_d = DW'(w_rd_val);
                                    state_d     = RESP_READ;
                                end
                                OP_SETBITS: begin
                                    if (!w_is_status) regs_d[w_addr] = regs_q[w_addr] | w_pay;
                                end
                                OP_CLRBITS: begin
                                    if (w_is_status) begin
                                        if (w_pay[0]) err_d = 1'b0;
                                    end else begin
                                        regs_d[w_addr] = regs_q[w_addr] & ~w_pay;
                                    end
                                end
                                OP_CLOCK: ;
                                default: err_d = 1'b1;
                            endcase
                        end
                    end
                end
                RESP_READ: begin
                    if (RespREQ) begin
                        state_d = IDLE;
                        fair_d  = 1'b0;
                    end
                end
                RESP_EVENT: begin
                    if (RespREQ) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge target_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            err_q       <= 1'b0;
            fair_q      <= 1'b0;
            resp_flag_q <= 1'b0;
            resp_dest_q <= 4'h0;
            resp_data_q <= '0;
            for (int i = 0; i < REGCOUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            fair_q      <= fair_d;
            resp_flag_q <= resp_flag_d;
            resp_dest_q <= resp_dest_d;
            resp_data_q <= resp_data_d;
            for (int i = 0; i < REGCOUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_command_responder.sv
`default_nettype none
// tb_io_command_responder - vector table plus response scoreboard for io_command_responder.
// Rev 1.0
module tb_io_command_responder;
    localparam logic [4:0] OP_WRITE = 5'h01, OP_READ = 5'h02, OP_SET = 5'h03,
                           OP_CLR = 5'h04, OP_CLOCK = 5'h1F;

    logic        target_clk = 1'b0;
    logic        async_rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        CmdACK = 1'b0;
    logic        CmdREQ;
    logic [3:0]  CmdDestReg = 4'h0;
    logic [31:0] CmdData = 32'h0;
    logic        RespACK;
    logic        RespREQ = 1'b0;
    logic        RespRegFlag;
    logic [3:0]  RespDestReg;
    logic [31:0] RespData;
    logic [7:0]  EventIn = 8'h0;
    logic [127:0] RegOut;

    io_command_responder dut (
        .target_clk (target_clk),
        .async_rst_n(async_rst_n),
        .clk_en     (clk_en),
        .CmdACK     (CmdACK),
        .CmdREQ     (CmdREQ),
        .CmdDestReg (CmdDestReg),
        .CmdData    (CmdData),
        .RespACK    (RespACK),
        .RespREQ    (RespREQ),
        .RespRegFlag(RespRegFlag),
        .RespDestReg(RespDestReg),
        .RespData   (RespData),
        .EventIn    (EventIn),
        .RegOut     (RegOut)
    );

    always #5 target_clk = ~target_clk;

    int errors = 0;
    int checks = 0;
    logic [36:0] sb_q[$];
    logic [36:0] log_q[$];
    bit          log_mode = 1'b0;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  addr;
        logic [15:0] pay;
        logic [3:0]  dest;
        bit          rd;
        logic [31:0] rdata;
        bit          chk;
        logic [15:0] regv;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: sample just after the falling edge, then advance to the next falling edge.
    task automatic tick(output bit acc);
        logic [36:0] got;
        #1;
        acc = CmdACK && CmdREQ && clk_en;
        if (RespACK && RespREQ && clk_en) begin
            got = {RespRegFlag, RespDestReg, RespData};
            if (log_mode) begin
                log_q.push_back(got);
            end else if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %h expected none", got);
            end else begin
                check("resp", 64'(got), 64'(sb_q.pop_front()));
            end
        end
        @(posedge target_clk);
        @(negedge target_clk);
    endtask

    task automatic send_cmd(input logic [4:0] op, input logic [2:0] addr, input logic [15:0] pay,
                            input logic [3:0] dest, input bit rd, input logic [31:0] rdata);
        bit acc = 1'b0;
        CmdACK     = 1'b1;
        CmdDestReg = dest;
        CmdData    = {op, addr, 8'h00, pay};
        for (int n = 0; n < 50 && !acc; n++) tick(acc);
        CmdACK  = 1'b0;
        CmdData = 32'h0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got no accept expected accept op=%h", op);
        end else if (rd) begin
            sb_q.push_back({1'b1, dest, rdata});
            check("read_latency", 64'(RespACK), 64'd1);
        end
    endtask

    task automatic drain();
        bit a;
        for (int n = 0; n < 30 && sb_q.size() > 0; n++) tick(a);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit a;
        int acc_t;
        logic [36:0] exp_log[4];

        vecs[0]  = '{OP_WRITE, 3'd2, 16'hBEEF, 4'h0, 1'b0, 32'h0,        1'b1, 16'hBEEF};
        vecs[1]  = '{OP_READ,  3'd2, 16'h0000, 4'h5, 1'b1, 32'h0000BEEF, 1'b0, 16'h0};
        vecs[2]  = '{OP_SET,   3'd1, 16'h00F0, 4'h0, 1'b0, 32'h0,        1'b1, 16'h00F0};
        vecs[3]  = '{OP_CLR,   3'd1, 16'h0030, 4'h0, 1'b0, 32'h0,        1'b1, 16'h00C0};
        vecs[4]  = '{OP_READ,  3'd1, 16'h0000, 4'h1, 1'b1, 32'h000000C0, 1'b0, 16'h0};
        vecs[5]  = '{5'h07,    3'd7, 16'h0000, 4'h0, 1'b0, 32'h0,        1'b1, 16'h0001};
        vecs[6]  = '{OP_READ,  3'd7, 16'h0000, 4'h2, 1'b1, 32'h00000001, 1'b0, 16'h0};
        vecs[7]  = '{OP_WRITE, 3'd7, 16'h0001, 4'h0, 1'b0, 32'h0,        1'b1, 16'h0000};
        vecs[8]  = '{OP_READ,  3'd7, 16'h0000, 4'h3, 1'b1, 32'h00000000, 1'b0, 16'h0};
        vecs[9]  = '{OP_SET,   3'd7, 16'hFFFF, 4'h0, 1'b0, 32'h0,        1'b1, 16'h0000};
        vecs[10] = '{OP_WRITE, 3'd0, 16'h1234, 4'h0, 1'b0, 32'h0,        1'b1, 16'h1234};
        vecs[11] = '{OP_CLOCK, 3'd0, 16'hFFFF, 4'h0, 1'b0, 32'h0,        1'b1, 16'h1234};
        vecs[12] = '{OP_READ,  3'd0, 16'h0000, 4'hF, 1'b1, 32'h00001234, 1'b0, 16'h0};
        vecs[13] = '{OP_WRITE, 3'd6, 16'hFFFF, 4'h0, 1'b0, 32'h0,        1'b1, 16'hFFFF};
        vecs[14] = '{OP_CLR,   3'd6, 16'h00FF, 4'h0, 1'b0, 32'h0,        1'b1, 16'hFF00};
        vecs[15] = '{OP_READ,  3'd6, 16'h0000, 4'h6, 1'b1, 32'h0000FF00, 1'b0, 16'h0};
        vecs[16] = '{5'h00,    3'd7, 16'h0000, 4'h0, 1'b0, 32'h0,        1'b1, 16'h0001};
        vecs[17] = '{OP_CLR,   3'd7, 16'h0001, 4'h0, 1'b0, 32'h0,        1'b1, 16'h0000};

        // Reset state
        clk_en  = 1'b1;
        RespREQ = 1'b1;
        @(negedge target_clk);
        @(negedge target_clk);
        #1;
        check("rst_cmdreq", 64'(CmdREQ), 64'd0);
        check("rst_respack", 64'(RespACK), 64'd0);
        check("rst_resp", 64'({RespRegFlag, RespDestReg, RespData}), 64'd0);
        check("rst_regout", 64'(RegOut == '0), 64'd1);
        @(negedge target_clk);
        async_rst_n = 1'b1;
        #1;
        check("idle_cmdreq", 64'(CmdREQ), 64'd1);
        clk_en = 1'b0;
        #1;
        check("clken_cmdreq", 64'(CmdREQ), 64'd0);
        clk_en = 1'b1;
        @(negedge target_clk);

        // Table-driven command vectors
        for (int i = 0; i < 18; i++) begin
            send_cmd(vecs[i].op, vecs[i].addr, vecs[i].pay, vecs[i].dest, vecs[i].rd, vecs[i].rdata);
            if (vecs[i].chk)
                check($sformatf("vec%0d_reg", i), 64'(RegOut[vecs[i].addr*16 +: 16]), 64'(vecs[i].regv));
        end
        drain();

        // Back-pressure during a read response
        RespREQ = 1'b0;
        send_cmd(OP_READ, 3'd2, 16'h0, 4'h3, 1'b1, 32'h0000BEEF);
        for (int n = 0; n < 10; n++) begin
            tick(a);
            check("bp_respack", 64'(RespACK), 64'd1);
            check("bp_hold", 64'({RespRegFlag, RespDestReg, RespData}), 64'({1'b1, 4'h3, 32'h0000BEEF}));
            check("bp_cmdreq", 64'(CmdREQ), 64'd0);
        end
        RespREQ = 1'b1;
        tick(a);
        check("bp_single", 64'(RespACK), 64'd0);
        check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Event pulse, with a second pulse landing in the launch cycle
        EventIn = 8'h05;
        sb_q.push_back({1'b0, 4'h0, 32'h00000005});
        tick(a);
        check("status_pending", 64'(RegOut[7*16 +: 16]), 64'h000A);
        EventIn = 8'h80;
        sb_q.push_back({1'b0, 4'h0, 32'h00000080});
        tick(a);
        check("launch_keeps_new", 64'(RegOut[7*16 +: 16]), 64'h0100);
        EventIn = 8'h00;
        drain();
        repeat (2) tick(a);
        send_cmd(OP_READ, 3'd7, 16'h0, 4'h4, 1'b1, 32'h0);
        drain();

        // Fairness: continuous events with a queued READ
        log_mode   = 1'b1;
        acc_t      = -1;
        CmdData    = {OP_READ, 3'd0, 8'h00, 16'h0};
        CmdDestReg = 4'h9;
        for (int t = 0; t < 6; t++) begin
            EventIn = 8'h01;
            CmdACK  = (t >= 1) && (acc_t < 0);
            tick(a);
            if (a) acc_t = t;
        end
        EventIn = 8'h00;
        CmdACK  = 1'b0;
        repeat (20) tick(a);
        log_mode = 1'b0;
        check("fair_accept_slot", 64'((acc_t >= 1) && (acc_t <= 3)), 64'd1);
        exp_log[0] = {1'b0, 4'h0, 32'h00000001};
        exp_log[1] = {1'b1, 4'h9, 32'h00001234};
        exp_log[2] = {1'b0, 4'h0, 32'h00000001};
        exp_log[3] = {1'b0, 4'h0, 32'h00000001};
        check("fair_resp_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check($sformatf("fair_resp%0d", i), 64'(log_q[i]), 64'(exp_log[i]));

        // Reset during a pending response drops it
        RespREQ = 1'b0;
        send_cmd(OP_READ, 3'd2, 16'h0, 4'h7, 1'b0, 32'h0);
        check("mid_respack", 64'(RespACK), 64'd1);
        async_rst_n = 1'b0;
        #1;
        check("mid_rst_respack", 64'(RespACK), 64'd0);
        check("mid_rst_regout", 64'(RegOut == '0), 64'd1);
        tick(a);
        async_rst_n = 1'b1;
        RespREQ     = 1'b1;
        repeat (5) tick(a);
        check("mid_no_replay", 64'(RespACK), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
